apb_reg_arbiter: RTL
====================

APB_REG_ARBITER -- requirements
Module: apb_reg_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters (2..8).
REQ-002 Parameter ADDR_WIDTH, 32, address width.
REQ-003 Parameter DATA_WIDTH, 32, data width.
REQ-004 Parameter TIMEOUT_CYCLES, 64, watchdog limit in pclk_i cycles (1..255).
REQ-005 pclk_i  input  1  single clock; all logic on rising edge.
REQ-006 prstn_i  input  1  reset, asynchronous, active-low.
REQ-007 req_valid_i  input  NUM_REQ  per-requester request.
REQ-008 req_write_i  input  NUM_REQ  per-requester direction (1 = write).
REQ-009 req_addr_i  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 req_wdata_i  input  NUM_REQ*DATA_WIDTH  packed write data; same packing.
REQ-011 req_grant_o  output  NUM_REQ  one-hot, one-cycle accept pulse.
REQ-012 req_done_o  output  NUM_REQ  one-hot, one-cycle completion pulse.
REQ-013 req_rdata_o  output  DATA_WIDTH  read data; valid while any req_done_o bit is high.
REQ-014 req_err_o  output  1  timeout flag; valid while any req_done_o bit is high.
REQ-015 reg_addr_o / reg_wdata_o  output  ADDR_WIDTH / DATA_WIDTH  to apb_master reg_addr_i / reg_wdata_i.
REQ-016 reg_enable_o / reg_write_o  output  1 / 1  to apb_master reg_enable_i / reg_write_i.
REQ-017 reg_rdata_i / reg_idle_i  input  DATA_WIDTH / 1  from apb_master reg_rdata_o / reg_idle_o.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP; all outputs registered.
REQ-019 IDLE: when any req_valid_i is high and reg_idle_i=1, select a winner round-robin from pointer ptr, latch its addr/wdata/write into reg_*_o, pulse req_grant_o[winner] next cycle, go to ISSUE.
REQ-020 Round-robin: search order ptr, ptr+1, ... wrapping modulo NUM_REQ; ptr becomes winner+1 (wrapping) on the RESP cycle.
REQ-021 ISSUE: reg_enable_o=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-022 WAIT_BUSY: on reg_idle_i=0 go to WAIT_DONE.
REQ-023 WAIT_DONE: on reg_idle_i=1 capture reg_rdata_i (reads only; writes capture 0) and go to RESP.
REQ-024 RESP: one cycle; req_done_o[winner]=1; req_rdata_o holds the captured data; req_err_o=0 for normal completion; then go to IDLE.
REQ-025 reg_addr_o, reg_wdata_o and reg_write_o are held stable from ISSUE through RESP.
REQ-026 A requester keeps req_valid_i high until it receives its grant; dropping valid earlier withdraws the request without a grant.
REQ-027 A requester whose valid is still high after its done pulse is re-arbitrated, rotating behind the others.
REQ-028 Minimum turnaround: grant-to-done is at least 4 cycles; one transaction is outstanding at a time.
REQ-029 While not in IDLE, new requests are ignored and no grant is issued.

Reset
REQ-030 prstn_i low asynchronously forces state=IDLE, ptr=0, and all outputs to 0; this applies mid-transaction, with no done pulse for an aborted transfer.
REQ-031 The first arbitration after reset starts at requester 0.

Configuration
REQ-032 Macro APB_ARB_TIMEOUT_EN defined: an 8-bit counter clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY/WAIT_DONE. On reaching TIMEOUT_CYCLES, go to RESP with req_err_o=1 and req_rdata_o=0, and ptr advances normally.
REQ-033 Macro APB_ARB_TIMEOUT_EN undefined: no counter exists, the FSM waits indefinitely, and req_err_o is tied to 0.

Verification
REQ-034 Single write: req0 valid, write=1, addr=0xDEADBEAF, wdata=0x12345678 -> grant[0] pulse, then one reg_enable_o pulse with those values on reg_*_o, then done[0] pulse with err=0.
REQ-035 Single read: req2 read at addr 0x10, slave returns 0xCAFEF00D -> done[2] with req_rdata_o=0xCAFEF00D.
REQ-036 All four requesters valid continuously from reset -> grant order 0,1,2,3,0, with no two grants overlapping.
REQ-037 Slave holds pready low indefinitely, macro defined, TIMEOUT_CYCLES=16 -> done after 16 cycles in wait states with err=1 and rdata=0; macro undefined -> no done pulse.
REQ-038 Assert prstn_i during WAIT_DONE -> all outputs 0 immediately and no done pulse; the next request from req3 with req0 also valid grants req0 first.

Source files
------------

// File: rtl/apb_reg_arbiter_if.sv
// apb_reg_arbiter_if
// Bundles the requester-side and register-bus-side signals of apb_reg_arbiter.
//
// Requester side (names seen from the arbiter):
//   req_valid_i / req_write_i  per-requester request and direction (1 = write)
//   req_addr_i / req_wdata_i   packed address / write data, requester i at
//                              [i*WIDTH +: WIDTH]
//   req_grant_o / req_done_o   one-hot, one-cycle accept / completion pulses
//   req_rdata_o / req_err_o    read data and timeout flag, valid with req_done_o
// Register-bus side (towards an apb_master):
//   reg_addr_o / reg_wdata_o / reg_write_o / reg_enable_o   command to the master
//   reg_rdata_i / reg_idle_i                                 response from the master
//
// Modports:
//   slave  - used by the arbiter (it serves the requesters and drives reg_*_o)
//   master - used by whatever sits around the arbiter (requesters + apb_master)
interface apb_reg_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_write_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]            req_grant_o;
  logic [NUM_REQ-1:0]            req_done_o;
  logic [DATA_WIDTH-1:0]         req_rdata_o;
  logic                          req_err_o;
  logic [ADDR_WIDTH-1:0]         reg_addr_o;
  logic [DATA_WIDTH-1:0]         reg_wdata_o;
  logic                          reg_enable_o;
  logic                          reg_write_o;
  logic [DATA_WIDTH-1:0]         reg_rdata_i;
  logic                          reg_idle_i;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    input  reg_rdata_i, reg_idle_i,
    output req_grant_o, req_done_o, req_rdata_o, req_err_o,
    output reg_addr_o, reg_wdata_o, reg_enable_o, reg_write_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    output reg_rdata_i, reg_idle_i,
    input  req_grant_o, req_done_o, req_rdata_o, req_err_o,
    input  reg_addr_o, reg_wdata_o, reg_enable_o, reg_write_o
  );
endinterface

// File: rtl/apb_reg_arbiter.sv
// apb_reg_arbiter
// Round-robin arbiter that lets NUM_REQ requesters share one apb_master
// register port. One transaction is outstanding at a time:
//   IDLE -> ISSUE (grant + one reg_enable_o pulse) -> WAIT_BUSY (master goes
//   busy) -> WAIT_DONE (master idle again, read data captured) -> RESP
//   (one-cycle done pulse) -> IDLE.
//
// Ports:
//   pclk_i   clock, rising edge
//   prstn_i  asynchronous active-low reset; aborts any transfer silently
//   bus      apb_reg_arbiter_if.slave, requester and register-bus signals
//
// Optional feature: define APB_ARB_TIMEOUT_EN to add an 8-bit watchdog that
// ends a transfer stuck in WAIT_BUSY/WAIT_DONE after TIMEOUT_CYCLES cycles,
// completing it with req_err_o=1 and req_rdata_o=0. Without the macro the
// FSM waits indefinitely and req_err_o stays 0.
module apb_reg_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               pclk_i,
  input  logic               prstn_i,
  apb_reg_arbiter_if.slave   bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("apb_reg_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_reg_arbiter: TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] pick;
`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0]       wd_cnt;
  logic             wd_expired;
`endif

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // First valid requester at or after ptr, wrapping. Only meaningful when
  // at least one valid bit is set.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] res;
    logic             found;
    idx   = p;
    res   = p;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && v[idx]) begin
        res   = idx;
        found = 1'b1;
      end
      idx = next_idx(idx);
    end
    return res;
  endfunction

  always_comb pick = rr_pick(bus.req_valid_i, ptr);

`ifdef APB_ARB_TIMEOUT_EN
  // wd_cnt counts completed wait cycles; the cycle in which it equals
  // TIMEOUT_CYCLES-1 is the last one allowed.
  always_comb wd_expired = (wd_cnt == 8'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      state            <= IDLE;
      ptr              <= '0;
      win              <= '0;
      bus.req_grant_o  <= '0;
      bus.req_done_o   <= '0;
      bus.req_rdata_o  <= '0;
      bus.req_err_o    <= 1'b0;
      bus.reg_addr_o   <= '0;
      bus.reg_wdata_o  <= '0;
      bus.reg_enable_o <= 1'b0;
      bus.reg_write_o  <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      wd_cnt           <= '0;
`endif
    end else begin
      case (state)
        // Arbitrate only when the master can take a command.
        IDLE: begin
          if ((|bus.req_valid_i) && bus.reg_idle_i) begin
            win              <= pick;
            bus.reg_addr_o   <= bus.req_addr_i[pick*ADDR_WIDTH +: ADDR_WIDTH];
            bus.reg_wdata_o  <= bus.req_wdata_i[pick*DATA_WIDTH +: DATA_WIDTH];
            bus.reg_write_o  <= bus.req_write_i[pick];
            bus.req_grant_o  <= NUM_REQ'(1) << pick;
            bus.reg_enable_o <= 1'b1;
            state            <= ISSUE;
          end
        end
        // Grant and enable are each high for this single cycle.
        ISSUE: begin
          bus.req_grant_o  <= '0;
          bus.reg_enable_o <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
          wd_cnt           <= '0;
`endif
          state            <= WAIT_BUSY;
        end
        // The master's idle drops once it has accepted the command.
        WAIT_BUSY: begin
          if (!bus.reg_idle_i) begin
            state <= WAIT_DONE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (wd_expired) begin
            bus.req_done_o  <= NUM_REQ'(1) << win;
            bus.req_rdata_o <= '0;
            bus.req_err_o   <= 1'b1;
            state           <= RESP;
          end
          wd_cnt <= wd_cnt + 8'd1;
`endif
        end
        // Idle rising again marks completion; normal completion wins over
        // a watchdog expiry in the same cycle.
        WAIT_DONE: begin
          if (bus.reg_idle_i) begin
            bus.req_done_o  <= NUM_REQ'(1) << win;
            bus.req_rdata_o <= bus.reg_write_o ? '0 : bus.reg_rdata_i;
            bus.req_err_o   <= 1'b0;
            state           <= RESP;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (wd_expired) begin
            bus.req_done_o  <= NUM_REQ'(1) << win;
            bus.req_rdata_o <= '0;
            bus.req_err_o   <= 1'b1;
            state           <= RESP;
          end
          wd_cnt <= wd_cnt + 8'd1;
`endif
        end
        // The winner drops to lowest priority for the next round.
        RESP: begin
          bus.req_done_o  <= '0;
          bus.req_rdata_o <= '0;
          bus.req_err_o   <= 1'b0;
          ptr             <= next_idx(win);
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
